// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO hub: default address map, STATUS bit layout,
// LFSR polynomial/seed and the default dot-update field layout.
package mmio_pkg;

  localparam int unsigned DEF_DOT_COUNT   = 450;
  localparam int unsigned DEF_DOT_BASE    = 100;
  localparam int unsigned DEF_RNG_ADDR    = 99;
  localparam int unsigned DEF_GEN_ADDR    = 98;
  localparam int unsigned DEF_STATUS_ADDR = 97;

  localparam int ST_EMPTY_BIT = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_OVF_BIT   = 2;
  localparam int ST_COUNT_LSB = 7;
  localparam int ST_COUNT_W   = 8;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

  localparam int DEF_ID_W  = $clog2(DEF_DOT_COUNT);
  localparam int DEF_LOC_W = 10;

  typedef struct packed {
    logic                 is_y;
    logic [DEF_ID_W-1:0]  id;
    logic [DEF_LOC_W-1:0] loc;
  } dot_upd_t;

  // Right-shifting Galois step; a non-zero state never maps to zero.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/dot_fifo.sv
// Synchronous FIFO for dot updates; a push into a full FIFO is accepted when a
// pop happens in the same cycle. Head word is read combinationally, zero when empty.
module dot_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_rd;
  logic             w_do_wr;

  assign empty   = (r_count == '0);
  assign full    = (r_count == (AW+1)'(DEPTH));
  assign count   = r_count;
  assign w_do_rd = rd_en & ~empty;
  assign w_do_wr = wr_en & (~full | w_do_rd);
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_do_wr) - (AW+1)'(w_do_rd);
    end
  end

endmodule

// File: rtl/mmio_hub.sv
// Memory-mapped I/O hub: address decode, dot-update queue, LFSR, generation
// counter, status register and a one-cycle-latency read mux aligned with RAM.
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int unsigned DOT_COUNT   = DEF_DOT_COUNT,
  parameter int unsigned DOT_BASE    = DEF_DOT_BASE,
  parameter int unsigned RNG_ADDR    = DEF_RNG_ADDR,
  parameter int unsigned GEN_ADDR    = DEF_GEN_ADDR,
  parameter int unsigned STATUS_ADDR = DEF_STATUS_ADDR,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          LOC_W       = DEF_LOC_W,
  parameter int unsigned GEN_MAX     = 9999,
  parameter int          RNG_ON_READ = 0,
  localparam int         ID_W        = $clog2(DOT_COUNT)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wren,
  input  logic [31:0]       address_dmem,
  input  logic [31:0]       data,
  input  logic [31:0]       ram_q,
  output logic              ram_wren,
  output logic [31:0]       q_dmem,
  input  logic              inc_seg7,
  output logic              dot_valid,
  input  logic              dot_ready,
  output logic              dot_is_y,
  output logic [ID_W-1:0]   dot_id,
  output logic [LOC_W-1:0]  dot_loc,
  output logic [13:0]       gen_value,
  output logic              overflow
);

  localparam logic [31:0] X_LO   = 32'(DOT_BASE);
  localparam logic [31:0] Y_LO   = 32'(DOT_BASE + DOT_COUNT);
  localparam logic [31:0] Y_HI   = 32'(DOT_BASE + 2 * DOT_COUNT);
  localparam logic [13:0] GEN_TOP = 14'(GEN_MAX);
  localparam int          FW     = 1 + ID_W + LOC_W;
  localparam int          CW     = $clog2(FIFO_DEPTH) + 1;

  logic          w_is_x, w_is_y, w_is_dot, w_is_rng, w_is_gen, w_is_status, w_is_ram;
  logic [ID_W-1:0] w_id;
  logic [FW-1:0] w_push_word;
  logic [FW-1:0] w_head;
  logic          w_full, w_empty, w_pop, w_dot_wr, w_drop;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status;
  logic [31:0]   w_rd_val;
  logic [13:0]   w_gen_load;

  logic [31:0]   r_lfsr;
  logic [13:0]   r_gen;
  logic          r_ovf;
  logic          r_rd_ram;
  logic [31:0]   r_rd_val;

  assign w_is_x      = (address_dmem >= X_LO) && (address_dmem < Y_LO);
  assign w_is_y      = (address_dmem >= Y_LO) && (address_dmem < Y_HI);
  assign w_is_dot    = w_is_x | w_is_y;
  assign w_is_rng    = (address_dmem == 32'(RNG_ADDR));
  assign w_is_gen    = (address_dmem == 32'(GEN_ADDR));
  assign w_is_status = (address_dmem == 32'(STATUS_ADDR));
  assign w_is_ram    = ~(w_is_dot | w_is_rng | w_is_gen | w_is_status);
  assign ram_wren    = wren & w_is_ram;

  assign w_id        = w_is_y ? ID_W'(address_dmem - Y_LO) : ID_W'(address_dmem - X_LO);
  assign w_push_word = {w_is_y, w_id, data[LOC_W-1:0]};
  assign w_pop       = ~w_empty & dot_ready;
  assign w_dot_wr    = wren & w_is_dot;
  assign w_drop      = w_dot_wr & w_full & ~w_pop;

  dot_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (w_dot_wr),
    .wr_data (w_push_word),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  assign dot_valid = ~w_empty;
  assign {dot_is_y, dot_id, dot_loc} = w_head;
  assign gen_value = r_gen;
  assign overflow  = r_ovf;
  assign w_gen_load = (data[13:0] <= GEN_TOP) ? data[13:0] : 14'd0;

  always_comb begin
    w_status = '0;
    w_status[ST_EMPTY_BIT] = w_empty;
    w_status[ST_FULL_BIT]  = w_full;
    w_status[ST_OVF_BIT]   = r_ovf;
    w_status[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(w_count);
  end

  always_comb begin
    w_rd_val = '0;
    if (w_is_rng)         w_rd_val = r_lfsr;
    else if (w_is_gen)    w_rd_val = {18'd0, r_gen};
    else if (w_is_status) w_rd_val = w_status;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else if ((RNG_ON_READ == 0) || (w_is_rng && !wren)) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  // A GEN write takes priority over a simultaneous increment pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gen <= '0;
    end else if (wren && w_is_gen) begin
      r_gen <= w_gen_load;
    end else if (inc_seg7) begin
      r_gen <= (r_gen >= GEN_TOP) ? 14'd0 : r_gen + 14'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (wren && w_is_status && data[ST_OVF_BIT]) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_ram <= 1'b0;
      r_rd_val <= '0;
    end else begin
      r_rd_ram <= w_is_ram;
      r_rd_val <= w_rd_val;
    end
  end

  assign q_dmem = r_rd_ram ? ram_q : r_rd_val;

endmodule

// File: tb/tb_mmio_hub.sv
// Randomised and directed bench for mmio_hub against a queue-based behavioural model.
module tb_mmio_hub;

  localparam int          ID_W    = 9;
  localparam int          LOC_W   = 10;
  localparam int          DEPTH   = 8;
  localparam int          GEN_MAX = 9999;
  localparam logic [31:0] TAPS    = 32'h8020_0003;
  localparam logic [31:0] SEED    = 32'hACE1_0001;

  logic              clock = 1'b0;
  logic              reset, wren, inc_seg7, dot_ready;
  logic [31:0]       address_dmem, data;
  logic [31:0]       ram_q = 32'h0;
  logic              ram_wren, dot_valid, dot_is_y, overflow;
  logic [31:0]       q_dmem;
  logic [ID_W-1:0]   dot_id;
  logic [LOC_W-1:0]  dot_loc;
  logic [13:0]       gen_value;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  always #5 clock = ~clock;

  mmio_hub #(.RNG_ON_READ(1)) dut (
    .clock(clock), .reset(reset), .wren(wren), .address_dmem(address_dmem),
    .data(data), .ram_q(ram_q), .ram_wren(ram_wren), .q_dmem(q_dmem),
    .inc_seg7(inc_seg7), .dot_valid(dot_valid), .dot_ready(dot_ready),
    .dot_is_y(dot_is_y), .dot_id(dot_id), .dot_loc(dot_loc),
    .gen_value(gen_value), .overflow(overflow)
  );

  // External synchronous RAM, driven by the DUT's write enable.
  bit [31:0] env_ram [int];
  always @(posedge clock) begin
    bit [31:0] old;
    old = env_ram.exists(int'(address_dmem)) ? env_ram[int'(address_dmem)] : 32'h0;
    if (ram_wren) env_ram[int'(address_dmem)] = data;
    ram_q <= old;
  end

  // Behavioural model state.
  typedef struct { int is_y; int id; int loc; } ent_t;
  ent_t      mq[$];
  bit        m_ovf;
  int        m_gen;
  bit [31:0] m_lfsr;
  bit [31:0] m_q;
  bit [31:0] m_ram [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // 0 RAM, 1 X, 2 Y, 3 RNG, 4 GEN, 5 STATUS
  function automatic int kind_of(input bit [31:0] a);
    if (a >= 100 && a < 550)  return 1;
    if (a >= 550 && a < 1000) return 2;
    if (a == 99) return 3;
    if (a == 98) return 4;
    if (a == 97) return 5;
    return 0;
  endfunction

  function automatic bit [31:0] lfsr_step(input bit [31:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
  endfunction

  task automatic model_step(input bit rst, input bit we, input bit [31:0] a,
                            input bit [31:0] d, input bit inc, input bit rdy);
    int k, sz;
    bit pop, full_before;
    bit [31:0] rv;
    ent_t e;
    k = kind_of(a);
    if (rst) begin
      mq.delete(); m_ovf = 0; m_gen = 0; m_lfsr = SEED; m_q = 0;
    end else begin
      sz = mq.size();
      full_before = (sz == DEPTH);
      pop = (sz > 0) && rdy;
      case (k)
        0: rv = m_ram.exists(int'(a)) ? m_ram[int'(a)] : 32'h0;
        3: rv = m_lfsr;
        4: rv = 32'(m_gen);
        5: rv = 32'(sz << 7) | 32'(m_ovf << 2) | 32'(full_before << 1) | 32'(sz == 0);
        default: rv = 32'h0;
      endcase
      if (k == 3 && !we) m_lfsr = lfsr_step(m_lfsr);
      if (pop) void'(mq.pop_front());
      if (we && (k == 1 || k == 2)) begin
        if (!full_before || pop) begin
          e.is_y = (k == 2);
          e.id   = (k == 2) ? int'(a) - 550 : int'(a) - 100;
          e.loc  = int'(d % 1024);
          mq.push_back(e);
        end else begin
          m_ovf = 1;
        end
      end else if (we && k == 5 && d[2]) begin
        m_ovf = 0;
      end
      if (we && k == 4) m_gen = ((d % 16384) <= GEN_MAX) ? int'(d % 16384) : 0;
      else if (inc) m_gen = (m_gen == GEN_MAX) ? 0 : m_gen + 1;
      m_q = rv;
    end
    if (we && k == 0) m_ram[int'(a)] = d;
  endtask

  task automatic compare_all();
    chk("dot_valid", 32'(dot_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("dot_is_y", 32'(dot_is_y), 32'(mq[0].is_y));
      chk("dot_id",   32'(dot_id),   32'(mq[0].id));
      chk("dot_loc",  32'(dot_loc),  32'(mq[0].loc));
    end
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("gen_value", 32'(gen_value), 32'(m_gen));
    chk("q_dmem",    q_dmem,         m_q);
  endtask

  task automatic step(input bit rst, input bit we, input bit [31:0] a,
                      input bit [31:0] d, input bit inc, input bit rdy);
    reset = rst; wren = we; address_dmem = a; data = d; inc_seg7 = inc; dot_ready = rdy;
    #1;
    chk("ram_wren", 32'(ram_wren), 32'(we && kind_of(a) == 0));
    model_step(rst, we, a, d, inc, rdy);
    @(posedge clock);
    #1;
    compare_all();
    txn++;
    $display("txn %0d rst=%0d we=%0d addr=%0d data=%08h inc=%0d rdy=%0d -> q=%08h valid=%0d gen=%0d ovf=%0d",
             txn, rst, we, a, d, inc, rdy, q_dmem, dot_valid, gen_value, overflow);
  endtask

  initial begin
    int r;
    bit [31:0] a, d;
    bit we, inc, rdy, rst;

    reset = 1; wren = 0; address_dmem = 0; data = 0; inc_seg7 = 0; dot_ready = 0;
    @(posedge clock); #1;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_q", q_dmem, 32'h0);
    chk("reset_valid", 32'(dot_valid), 32'h0);

    // First dot writes: X block base and last Y address.
    step(0, 1, 100, 37, 0, 0);
    chk("x0_id", 32'(dot_id), 32'd0);
    chk("x0_loc", 32'(dot_loc), 32'd37);
    chk("x0_is_y", 32'(dot_is_y), 32'd0);
    step(0, 1, 999, 412, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("y449_id", 32'(dot_id), 32'd449);
    chk("y449_is_y", 32'(dot_is_y), 32'd1);
    chk("y449_loc", 32'(dot_loc), 32'd412);
    step(0, 0, 0, 0, 0, 1);

    // Fill, overflow, status, clear.
    for (int i = 0; i < 8; i++) step(0, 1, 32'(100 + i), 32'(i + 1), 0, 0);
    step(0, 0, 97, 0, 0, 0);
    chk("status_full", q_dmem, 32'h402);
    step(0, 1, 108, 9, 0, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    step(0, 1, 97, 32'h4, 0, 0);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full plus simultaneous pop, then drain in order.
    step(0, 1, 600, 77, 0, 1);
    chk("full_pop_ovf", 32'(overflow), 32'd0);
    chk("full_pop_head", 32'(dot_loc), 32'd2);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 1);

    // Generation counter.
    step(0, 1, 98, 9999, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("gen_wrap", 32'(gen_value), 32'd0);
    step(0, 1, 98, 12345, 0, 0);
    chk("gen_big", 32'(gen_value), 32'd0);
    step(0, 1, 98, 5, 1, 0);
    chk("gen_wr_wins", 32'(gen_value), 32'd5);

    // RNG on read.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 99, 0, 0, 0);
    chk("rng_first", q_dmem, 32'hACE1_0001);
    step(0, 0, 99, 0, 0, 0);
    chk("rng_second", q_dmem, 32'hD650_8003);
    for (int i = 0; i < 3; i++) step(0, 0, 5, 0, 0, 0);
    step(0, 0, 99, 0, 0, 0);
    chk("rng_third", q_dmem, 32'hEB08_4002);

    // RAM path.
    step(0, 1, 2000, 32'hDEAD_BEEF, 0, 0);
    step(0, 0, 2000, 0, 0, 0);
    step(0, 0, 3, 0, 0, 0);
    step(0, 0, 2000, 0, 0, 0);
    chk("ram_read", q_dmem, 32'hDEAD_BEEF);
    reset = 0; wren = 1; address_dmem = 98; #1;
    chk("ram_wren_gen", 32'(ram_wren), 32'd0);

    // Randomised traffic.
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 11));
      case (r)
        0: a = 32'($urandom_range(100, 999));
        1: a = 100;
        2: a = 549;
        3: a = 550;
        4: a = 999;
        5: a = 99;
        6: a = 98;
        7: a = 97;
        8: a = 32'($urandom_range(1000, 1001));
        9: a = 96;
        default: a = 32'($urandom_range(2000, 2007));
      endcase
      d   = $urandom;
      if (a == 98 && $urandom_range(0, 1) == 1) d = 32'($urandom_range(9990, 10010));
      we  = ($urandom_range(0, 1) == 1);
      inc = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step(rst, we, a, d, inc, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_hub.md
# mmio_hub

Parametrised memory-mapped I/O hub between the processor data-memory port, data RAM and on-board peripherals. Decodes dot-location writes into a buffered valid/ready stream for the VGA controller. Provides a pseudo-random number register, a generation counter for the 7-segment display, and a status/control register. All reads are returned with one-cycle latency, aligned with the synchronous RAM.

## Interface
Parameters:
- DOT_COUNT, 450 — dot channels; X block at DOT_BASE, Y block at DOT_BASE+DOT_COUNT
- DOT_BASE, 100 — first dot X address
- RNG_ADDR, 99 — random-number read address
- GEN_ADDR, 98 — generation counter read/write address
- STATUS_ADDR, 97 — status read / overflow-clear write address
- FIFO_DEPTH, 8 — dot update queue depth, power of two, ≥2
- LOC_W, 10 — dot coordinate width
- GEN_MAX, 9999 — generation counter wrap value
- RNG_ON_READ, 0 — 0: LFSR steps every cycle; 1: steps only on an RNG read

Ports (ID_W = clog2(DOT_COUNT)):
- clock  in  1  single system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- wren  in  1  processor data write enable
- address_dmem  in  32  processor data address
- data  in  32  processor write data
- ram_q  in  32  RAM read data, valid one cycle after its address
- ram_wren  out  1  RAM write enable, suppressed for MMIO addresses
- q_dmem  out  32  read data to processor
- inc_seg7  in  1  generation-increment pulse
- dot_valid  out  1  dot update available
- dot_ready  in  1  VGA accepts the update
- dot_is_y  out  1  update targets the Y coordinate
- dot_id  out  ID_W  dot index
- dot_loc  out  LOC_W  coordinate (data[LOC_W-1:0])
- gen_value  out  14  generation count to the 7-segment driver
- overflow  out  1  sticky: a dot write was dropped

## Operation
- Decode is combinational on address_dmem:
  - X when DOT_BASE ≤ a < DOT_BASE+DOT_COUNT.
  - Y when DOT_BASE+DOT_COUNT ≤ a < DOT_BASE+2·DOT_COUNT.
  - RNG, GEN and STATUS on an exact match.
  - Anything else is RAM.
- ram_wren = wren & RAM-decode.
- Dot write: push {is_y, id = a − block base, data[LOC_W-1:0]} into the FIFO.
  - Accepted if the FIFO is not full, or a pop occurs in the same cycle.
  - Otherwise the write is dropped and overflow is set.
- FIFO output:
  - dot_valid = not empty.
  - Pop when dot_valid & dot_ready.
  - Outputs are held stable while valid & !ready.
  - No bypass path.
- LFSR: 32-bit Galois, taps 0x80200003. The all-zero state is illegal and never reached.
- Generation counter:
  - inc_seg7 adds 1; GEN_MAX wraps to 0.
  - A GEN write loads data[13:0] if ≤ GEN_MAX, else loads 0.
  - A GEN write and inc_seg7 in the same cycle: the write wins.
- STATUS read: bit0 empty, bit1 full, bit2 overflow, bits[7+:8] FIFO occupancy, all other bits 0.
- STATUS write with data[2]=1 clears overflow. If a drop occurs in the same cycle, set wins.
- Reads to a dot address return 0.

## Timing
- Read latency is 1 cycle.
  - The read-source select and the RNG/GEN/STATUS values are registered in cycle N.
  - q_dmem is valid in cycle N+1.
  - For a RAM source, q_dmem = ram_q in cycle N+1.
- RNG_ON_READ=1: the value returned is the pre-step value; the LFSR steps at the end of cycle N.
- Push-to-valid latency is 1 cycle. Occupancy is updated at the edge.
- Reset values:
  - FIFO empty; dot_valid=0; dot_is_y=0; dot_id=0; dot_loc=0.
  - overflow=0; gen_value=0; q_dmem=0; LFSR=0xACE10001; ram_wren follows its inputs.
- Reset mid-operation flushes all queued updates. dot_ready is ignored during reset.

## Structure
- Package mmio_pkg holds:
  - Default address constants.
  - STATUS bit indices.
  - LFSR taps and seed.
  - The dot-update struct/field widths.
- Sub-module dot_fifo: a synchronous FIFO with parametrised width/depth, wr_en/rd_en, full/empty/count, and simultaneous push+pop when full.
- The hub holds the decode, the LFSR, the generation counter and the read mux.

## Test plan
- After reset:
  - Write 37 to 100 → dot_valid=1 next cycle, id=0, is_y=0, loc=37.
  - Write 412 to 999 → id=449, is_y=1, loc=412.
- FIFO fill and overflow:
  - Hold dot_ready=0 and issue 9 dot writes → full=1 after 8, overflow=1 after the 9th.
  - STATUS reads 0x402 (count 8, full).
  - Write 0x4 to 97 → overflow=0.
- Full with simultaneous pop: with dot_ready=1 and a push in the same cycle → push accepted, overflow stays 0, entry order preserved.
- Generation counter:
  - Write 9999 to 98, pulse inc_seg7 → gen_value=0.
  - Write 12345 to 98 → 0.
  - Write 5 with inc_seg7 in the same cycle → 5.
- RNG, RNG_ON_READ=1:
  - First read of 99 after reset returns 0xACE10001.
  - Second read returns the next LFSR state.
  - Idle cycles do not change the value.
- RAM path:
  - Write 0xDEADBEEF to 2000 → ram_wren=1.
  - Read 2000 → q_dmem=ram_q one cycle later.
  - Write to 98 → ram_wren=0.
